sid_voice_sched: RTL and testbench

SID_VOICE_SCHED -- requirements
Module: sid_voice_sched

---
 rtl/sid_voice_sched.sv | 110 +++++++++++
 tb/tb_sid_voice_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_sched.sv
// Voice scheduler for the shared SID envelope datapath: walks PHI2 / PHI2_PHI1
// slots for each voice after every tick and lets bus writes land in their voice's PHI2 slot.
package sid;
  typedef logic [1:0] phase_t;
  localparam int PHI2      = 0;
  localparam int PHI2_PHI1 = 1;
endpackage

module sid_voice_sched #(
  parameter int VOICES = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        tick,
  // Write handshake: wr_req is held with wr_voice/wr_addr/wr_data stable until
  // the one-cycle wr_ack; a request still high after its ack counts as a new one.
  input  logic        wr_req,
  input  logic [1:0]  wr_voice,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        reg_we,
  output logic [1:0]  reg_voice,
  output logic [2:0]  reg_addr,
  output logic [7:0]  reg_data,
  output sid::phase_t phase,
  output logic [1:0]  voice,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P2   = 2'd1,
    S_P21  = 2'd2
  } state_t;

  localparam logic [1:0]  LAST_VOICE = 2'(VOICES - 1);
  localparam logic [2:0]  NUM_VOICES = 3'(VOICES);
  localparam sid::phase_t PH_P2      = sid::phase_t'(1 << sid::PHI2);
  localparam sid::phase_t PH_P21     = sid::phase_t'(1 << sid::PHI2_PHI1);

  state_t state;
  logic   wr_valid;

  // The (state, voice) pair is the full FSM state: P2(v) is S_P2 with voice == v.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= S_IDLE;
      phase   <= '0;
      voice   <= '0;
      overrun <= 1'b0;
    end else begin
      if (tick && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_P2;
            phase <= PH_P2;
            voice <= '0;
          end
        end
        S_P2: begin
          state <= S_P21;
          phase <= PH_P21;
        end
        S_P21: begin
          if (voice == LAST_VOICE) begin
            state <= S_IDLE;
            phase <= '0;
          end else begin
            state <= S_P2;
            phase <= PH_P2;
            voice <= voice + 2'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          phase <= '0;
        end
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign wr_valid = ({1'b0, wr_voice} < NUM_VOICES);

  // Valid-voice writes only commit in their own PHI2 slot; invalid voices are
  // rejected while idle so they never compete with a commit.
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    reg_we = 1'b0;
    if (!res && wr_req) begin
      if (wr_valid && state == S_P2 && wr_voice == voice) begin
        wr_ack = 1'b1;
        reg_we = 1'b1;
      end else if (!wr_valid && state == S_IDLE) begin
        wr_ack = 1'b1;
        wr_err = 1'b1;
      end
    end
  end

  assign reg_voice = wr_voice;
  assign reg_addr  = wr_addr;
  assign reg_data  = wr_data;

endmodule

// File: tb/tb_sid_voice_sched.sv
// Bench for sid_voice_sched: per-cycle expected outputs from a slot-counter
// reference are queued, then compared against the DUT at the falling edge.
module tb_sid_voice_sched;
  localparam int VOICES = 3;
  localparam int W      = 22;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        tick = 1'b0;
  logic        wr_req = 1'b0;
  logic [1:0]  wr_voice = '0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack, wr_err, reg_we;
  logic [1:0]  reg_voice;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_data;
  sid::phase_t phase;
  logic [1:0]  voice;
  logic        busy, overrun;

  sid_voice_sched #(.VOICES(VOICES)) dut (
    .clk(clk), .res(res), .tick(tick), .wr_req(wr_req),
    .wr_voice(wr_voice), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .reg_we(reg_we),
    .reg_voice(reg_voice), .reg_addr(reg_addr), .reg_data(reg_data),
    .phase(phase), .voice(voice), .busy(busy), .overrun(overrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cyc  = -1;
  int err_cyc  = -1;
  int ack_cnt  = 0;
  int busy_cnt = 0;
  bit hold_req = 1'b0;

  // reference: m_k is the slot index within the sequence, -1 when idle
  int         m_k     = -1;
  logic [1:0] m_voice = '0;
  logic       m_ovr   = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock cycle: queue expectation, compare at negedge, advance reference
  task automatic step();
    logic [W-1:0] e;
    logic [W-1:0] obs;
    logic         e_busy, e_ack, e_err, e_we, valid;
    sid::phase_t  e_phase;
    logic [1:0]   e_voice;
    e_busy  = (m_k >= 0);
    e_phase = '0;
    if (m_k >= 0) begin
      if (m_k % 2 == 0) e_phase[sid::PHI2] = 1'b1;
      else              e_phase[sid::PHI2_PHI1] = 1'b1;
    end
    e_voice = (m_k >= 0) ? 2'(m_k / 2) : m_voice;
    valid   = (int'(wr_voice) < VOICES);
    e_ack   = !res && wr_req &&
              ((m_k >= 0 && m_k % 2 == 0 && valid && int'(wr_voice) == m_k / 2) ||
               (m_k < 0 && !valid));
    e_err   = e_ack && !valid;
    e_we    = e_ack && valid;
    e = {e_busy, e_phase, e_voice, e_ack, e_err, e_we, m_ovr,
         (e_we ? {wr_voice, wr_addr, wr_data} : 13'h0)};
    exp_q.push_back(e);

    @(negedge clk);
    obs = {busy, phase, voice, wr_ack, wr_err, reg_we, overrun,
           (reg_we ? {reg_voice, reg_addr, reg_data} : 13'h0)};
    check($sformatf("cyc%0d", cyc), obs, exp_q.pop_front());
    if (wr_ack) begin
      if (ack_cyc < 0) ack_cyc = cyc;
      ack_cnt++;
    end
    if (wr_err && err_cyc < 0) err_cyc = cyc;
    if (busy) busy_cnt++;

    if (res) begin
      m_k = -1; m_voice = '0; m_ovr = 1'b0;
    end else if (m_k < 0) begin
      if (tick) m_k = 0;
    end else begin
      if (tick) m_ovr = 1'b1;
      m_voice = 2'(m_k / 2);
      m_k = (m_k + 1 == 2 * VOICES) ? -1 : m_k + 1;
    end

    @(posedge clk);
    #1;
    tick = 1'b0;
    res  = 1'b0;
    if (e_ack && !hold_req) wr_req = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    wr_req = 1'b0;
    hold_req = 1'b0;
    res = 1'b1; step();
    res = 1'b1; step();
    cyc = 0; ack_cyc = -1; err_cyc = -1; ack_cnt = 0; busy_cnt = 0;
  endtask

  task automatic raise_req(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d);
    wr_voice = v; wr_addr = a; wr_data = d; wr_req = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    do_reset();

    // basic sequence
    tick = 1'b1; run(9);
    check("basic_busy_cycles", W'(busy_cnt), W'(6));

    // deferred write to voice 2 lands in P2(2)
    do_reset();
    raise_req(2'd2, 3'd4, 8'h41); tick = 1'b1; run(9);
    check("deferred_ack_cycle", W'(ack_cyc), W'(5));

    // invalid voice rejected immediately while idle
    do_reset();
    raise_req(2'd3, 3'd1, 8'h99); run(2);
    check("invalid_err_cycle", W'(err_cyc), W'(0));

    // tick during last P21 is dropped
    do_reset();
    tick = 1'b1; run(6); tick = 1'b1; run(6);
    check("overrun_set", W'(overrun), W'(1));
    check("overrun_no_restart", W'(busy_cnt), W'(6));

    // minimum tick period: back-to-back sequences
    do_reset();
    tick = 1'b1; run(7); tick = 1'b1; run(8);
    check("min_period_no_overrun", W'(overrun), W'(0));
    check("min_period_busy", W'(busy_cnt), W'(12));

    // reset mid-sequence keeps the pending write for the next sequence
    do_reset();
    raise_req(2'd1, 3'd2, 8'h5a); tick = 1'b1; run(3);
    res = 1'b1; run(2);
    tick = 1'b1; run(6);
    check("reset_pending_ack_cycle", W'(ack_cyc), W'(8));

    // reset and tick together: no sequence, no overrun
    do_reset();
    res = 1'b1; tick = 1'b1; run(4);
    check("res_tick_busy", W'(busy_cnt), W'(0));

    // held request is written again at the next matching slot
    do_reset();
    hold_req = 1'b1;
    raise_req(2'd0, 3'd7, 8'hc3); tick = 1'b1; run(7); tick = 1'b1; run(7);
    check("held_req_acks", W'(ack_cnt), W'(2));
    hold_req = 1'b0; wr_req = 1'b0;

    // random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if (!wr_req && $urandom_range(0, 2) == 0)
        raise_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      tick = ($urandom_range(0, 5) == 0);
      res  = ($urandom_range(0, 60) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
